pipe_mux: RTL

Parametrised N-way operand-select mux with a registered valid/ready output stage and a two-entry skid buffer. It is the successor to the fixed 2:1 32-bit datapath mux. It sits between pipeline stages of the 32-bit RISC-V core, for example forwarding-path selection in front of the execute stage. It keeps full throughput under backpressure, and no combinational path runs from `out_ready` to `in_ready`. Selection of a non-existent input is flagged rather than silently aliased.

---
 rtl/pipe_mux.sv | 65 ++++++
 1 files changed

// File: rtl/pipe_mux.sv
// pipe_mux: N-way operand-select mux feeding a registered valid/ready stage with a two-entry skid buffer.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] main_q, main_d, skid_q, skid_d, pick;
  logic acc, pop;
  // An index with no matching input leaves the all-zero word with the error bit set.
  always_comb begin
    pick = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) pick = {1'b0, in_data[k*WIDTH +: WIDTH]};
  end
  assign in_ready  = !rst && state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign {out_err, out_data} = main_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        main_d  = pick;
      end
      ONE: if (acc && pop) main_d = pick;
      else if (acc) begin
        state_d = TWO;
        skid_d  = pick;
      end else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule
